// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared states, widths and length encoding for prog_loader
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  // The length field is one byte; a value of zero stands for a full 256-byte image.
  localparam int LEN_W = 8;
  localparam int CNT_W = LEN_W + 1;
  localparam logic [CNT_W-1:0] LEN_ZERO_COUNT = 9'd256;

  localparam int CSUM_W = 8;

  // Convert the raw length byte into the number of payload bytes to expect.
  function automatic logic [CNT_W-1:0] len_to_count(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_ZERO_COUNT : {1'b0, len};
  endfunction

endpackage

// File: rtl/prog_loader_csum.sv
// rtl/prog_loader_csum.sv - 8-bit additive image checksum (clear/add/check)
module prog_loader_csum
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              add_en,
  input  logic [CSUM_W-1:0] add_byte,
  input  logic [CSUM_W-1:0] trailer,
  output logic              match
);

  logic [CSUM_W-1:0] sum;
  logic [CSUM_W-1:0] total;

  // Running mod-256 sum of the length byte and every payload byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + add_byte;
    end
  end

  // The trailer is chosen by the image builder so that the whole image sums to zero.
  always_comb begin
    total = sum + trailer;
    match = (total == '0);
  end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a length-prefixed program image into instruction RAM; PROG_LOADER_CHECKSUM_EN adds a trailing checksum byte
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              write_req,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr;
  logic              beat;
  logic              last_data;
  logic              can_start;
  logic              csum_ok;

  assign beat      = in_valid & in_ready;
  assign last_data = (cnt == CNT_W'(1));
  assign can_start = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic csum_clear;
  logic csum_add;

  assign csum_clear = start && can_start;
  assign csum_add   = beat && ((state == ST_LEN) || (state == ST_DATA));

  prog_loader_csum u_csum (
    .clk      (clk),
    .reset    (reset),
    .clear    (csum_clear),
    .add_en   (csum_add),
    .add_byte (in_data[CSUM_W-1:0]),
    .trailer  (in_data[CSUM_W-1:0]),
    .match    (csum_ok)
  );
`else
  assign csum_ok = 1'b1;
`endif

  // State register; reset aborts any load in progress immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs; every transition out of a load state needs a beat.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    cpu_hold  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_LEN;
      end
      ST_LEN: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (beat) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (beat && last_data) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_nxt = ST_CSUM;
`else
          state_nxt = ST_DONE;
`endif
        end
      end
      ST_CSUM: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (beat) state_nxt = csum_ok ? ST_DONE : ST_ERR;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_nxt = ST_LEN;
      end
      ST_ERR: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        err = 1'b1;
`endif
        if (start) state_nxt = ST_LEN;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Byte counter, write address and the registered RAM write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      addr      <= '0;
      write_req <= 1'b0;
      w_addr    <= '0;
      w_data    <= '0;
    end else begin
      write_req <= 1'b0;
      if (beat && (state == ST_LEN)) begin
        cnt  <= len_to_count(in_data[LEN_W-1:0]);
        addr <= BASE_ADDR;
      end
      if (beat && (state == ST_DATA)) begin
        write_req <= 1'b1;
        w_addr    <= addr;
        w_data    <= in_data;
        addr      <= addr + ADDR_W'(1);
        cnt       <= cnt - CNT_W'(1);
      end
    end
  end

endmodule
